pw_setter: RTL
==============

Name: pw_setter

Overview:
- Password-enrollment block; the writer side of the password checker.
- The user enters a new 4-digit code twice on one-hot switches sw[9:0]. On a match, the code is committed to a register that the checker reads as its reference password.
- Current entry progress is shown on HEX4..HEX0, and the FSM state is exported on states for debug LEDs.

Parameters:
- NUM_DIGITS, 4, digits per code; fixed at 4 in this revision.
- DEFAULT_PW, 16'h0123, BCD value loaded into pw_digits at reset (digit3 in [15:12]).
- ERR_CYCLES, 50, cycles the ERROR state is held before returning to IDLE; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  10  one-hot digit keys; bit i means digit i.
- set_req  in  1  level; starts enrollment when sampled high in IDLE.
- pw_digits  out  16  committed password, 4 BCD nibbles; [15:12] is the first digit entered.
- pw_valid  out  1  high once any enrollment has committed since reset.
- pw_done  out  1  one-cycle pulse in the cycle COMMIT is occupied.
- HEX4, HEX3, HEX2, HEX1, HEX0  out  7 each  active-low segments, bit order gfedcba.
- states  out  5  one-hot state: {ERROR, COMMIT, CONFIRM, ENTER1, IDLE}.

Behaviour:
- Reset state:
  - FSM=IDLE, states=5'b00001.
  - pw_digits=DEFAULT_PW, pw_valid=0, pw_done=0.
  - Entry buffers A and B cleared to 0; digit counter=0; sw_q=0; error timer=0.
  - HEX3..HEX0 show dash, HEX4 blank.
- Reset during any state aborts enrollment and reloads DEFAULT_PW.
- Press detection:
  - sw_q is sw registered every cycle.
  - A press occurs when sw_q==0, sw!=0 and sw is one-hot.
  - The digit is the index of the set bit. It is written into the current buffer slot at that clock edge, and the counter increments.
  - A non-one-hot sw, or sw held across cycles, produces no press. Keys must return to 0 between digits.
- FSM transitions:
  - IDLE: set_req=1 -> ENTER1, counter=0, buffers A and B cleared. Presses are ignored in IDLE.
  - ENTER1: each press fills buffer A slot[counter]. The 4th press -> CONFIRM in the next cycle, counter=0.
  - CONFIRM: each press fills buffer B. The 4th press -> compare A with B (including the digit just captured). Equal -> COMMIT; unequal -> ERROR.
  - COMMIT: lasts exactly one cycle. pw_digits<=A, pw_valid<=1, pw_done=1 during this cycle. Next state is IDLE.
  - ERROR: timer counts ERR_CYCLES cycles, then -> IDLE. pw_digits is unchanged, and presses are ignored.
- set_req is ignored outside IDLE and does not restart an entry in progress. set_req held high after COMMIT or ERROR re-enters ENTER1 on the first IDLE cycle.
- Latency:
  - Last confirm press edge -> COMMIT occupied in the following cycle.
  - pw_digits and pw_valid are updated at the COMMIT-to-IDLE edge.
- Display, combinational from registered state:
  - IDLE: HEX3..HEX0 show dash, HEX4 blank.
  - ENTER1 and CONFIRM: HEX4 shows 1 or 2 respectively. Slots already entered in the current buffer show their digit; unentered slots are blank. The first digit is on HEX3.
  - COMMIT: same as IDLE.
  - ERROR: HEX4 blank, HEX3..HEX0 = blank, E, r, r.
- Glyphs:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - dash = 0111111, blank = 1111111, E = 0000110, r = 0101111.

Test Plan:
- Reset: rst=1 for 2 cycles -> pw_digits=16'h0123, pw_valid=0, states=5'b00001, HEX3..HEX0=0111111.
- Matching enrollment: set_req pulse; enter 4,7,0,9 twice (sw one-hot for 1 cycle each, 0 between) -> pw_done single pulse; pw_digits=16'h4709; pw_valid=1; returns to IDLE.
- Mismatch: enter 1,2,3,4 then 1,2,3,5 -> states=5'b10000 for exactly ERR_CYCLES cycles with HEX0=0101111 (r); pw_digits stays 16'h4709; then IDLE.
- Illegal and held keys:
  - sw=10'b0000000011 during ENTER1 -> counter unchanged.
  - sw=10'b0000001000 held 5 cycles -> exactly one digit (3) captured; HEX3=0110000.
- Mid-operation reset: rst asserted after 2 confirm digits -> next cycle IDLE, pw_digits=16'h0123, pw_valid=0.
- set_req and IDLE presses: presses while in IDLE are ignored; set_req toggled during ENTER1 does not restart entry (counter keeps advancing).

Source files
------------

// File: rtl/pw_setter.sv
// Password enrollment: a 4-digit code is entered twice on one-hot keys and,
// when both entries agree, committed as the reference password for the checker.
module pw_setter #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [15:0] DEFAULT_PW = 16'h0123,
    parameter int          ERR_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sw,
    input  logic        set_req,
    output logic [15:0] pw_digits,
    output logic        pw_valid,
    output logic        pw_done,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0,
    output logic [4:0]  states
);

    localparam int CW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(ERR_CYCLES + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        ENTER1  = 5'b00010,
        CONFIRM = 5'b00100,
        COMMIT  = 5'b01000,
        ERROR   = 5'b10000
    } state_t;

    typedef logic [NUM_DIGITS-1:0][3:0] code_t;

    state_t          state, state_next;
    logic [9:0]      sw_q;
    code_t           buf_a, buf_b, b_next, cur;
    logic [CW-1:0]   cnt, slot;
    logic [TW-1:0]   err_timer;
    logic [3:0]      digit;
    logic            one_hot, press, last, match, err_done;
    logic [6:0]      disp [NUM_DIGITS];

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    endfunction

    // A press is the first cycle of a single key going down from all-released.
    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++)
            if (sw[i]) digit = 4'(i);
        one_hot  = (sw != '0) && ((sw & (sw - 10'd1)) == '0);
        press    = (sw_q == '0) && one_hot;
        last     = press && (cnt == CW'(NUM_DIGITS - 1));
        slot     = CW'(NUM_DIGITS - 1) - cnt;
        b_next   = buf_b;
        b_next[slot] = digit;
        match    = (buf_a == b_next);
        err_done = (err_timer == TW'(ERR_CYCLES - 1));
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (set_req) state_next = ENTER1;
            ENTER1:  if (last) state_next = CONFIRM;
            CONFIRM: if (last) state_next = match ? COMMIT : ERROR;
            COMMIT:  state_next = IDLE;
            ERROR:   if (err_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the entry buffers are small register files, so they are reset explicitly rather than left undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q      <= '0;
            buf_a     <= '0;
            buf_b     <= '0;
            cnt       <= '0;
            err_timer <= '0;
            pw_digits <= DEFAULT_PW;
            pw_valid  <= 1'b0;
        end else begin
            sw_q <= sw;
            case (state)
                IDLE: if (set_req) begin
                    cnt   <= '0;
                    buf_a <= '0;
                    buf_b <= '0;
                end
                ENTER1: if (press) begin
                    buf_a[slot] <= digit;
                    cnt         <= last ? '0 : cnt + CW'(1);
                end
                CONFIRM: if (press) begin
                    buf_b[slot] <= digit;
                    cnt         <= last ? '0 : cnt + CW'(1);
                end
                COMMIT: begin
                    pw_digits <= buf_a;
                    pw_valid  <= 1'b1;
                end
                ERROR: err_timer <= err_done ? '0 : err_timer + TW'(1);
                default: ;
            endcase
        end
    end

    // Display: slot k of the active buffer goes on HEX(3-k) once it has been entered.
    always_comb begin
        states  = state;
        pw_done = (state == COMMIT);
        HEX4    = SEG_BLANK;
        cur     = (state == ENTER1) ? buf_a : buf_b;
        for (int k = 0; k < NUM_DIGITS; k++)
            disp[k] = SEG_DASH;
        case (state)
            ENTER1, CONFIRM: begin
                HEX4 = (state == ENTER1) ? seg(4'd1) : seg(4'd2);
                for (int k = 0; k < NUM_DIGITS; k++)
                    disp[NUM_DIGITS-1-k] = (k < int'(cnt)) ? seg(cur[NUM_DIGITS-1-k]) : SEG_BLANK;
            end
            ERROR: begin
                disp[3] = SEG_BLANK;
                disp[2] = SEG_E;
                disp[1] = SEG_R;
                disp[0] = SEG_R;
            end
            default: ;
        endcase
        HEX3 = disp[3];
        HEX2 = disp[2];
        HEX1 = disp[1];
        HEX0 = disp[0];
    end

endmodule
